// File: rtl/track_map_arbiter_if.sv
// Track map port bundle: render fetch, physics handshake and the BRAM read port.
// The arbiter sits on the slave side; requesters and the BRAM sit on the master side.
interface track_map_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 4
);
    logic              rv_req_in;
    logic [ADDR_W-1:0] rv_addr_in;
    logic              rv_valid_out;
    logic [DATA_W-1:0] rv_data_out;

    logic              ph_req_in;
    logic [ADDR_W-1:0] ph_addr_in;
    logic              ph_ready_out;
    logic              ph_valid_out;
    logic [DATA_W-1:0] ph_data_out;
    logic [7:0]        ph_wait_out;

    logic              mem_en_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_data_in;

    modport slave (
        input  rv_req_in, rv_addr_in, ph_req_in, ph_addr_in, mem_data_in,
        output rv_valid_out, rv_data_out, ph_ready_out, ph_valid_out,
               ph_data_out, ph_wait_out, mem_en_out, mem_addr_out
    );

    modport master (
        output rv_req_in, rv_addr_in, ph_req_in, ph_addr_in, mem_data_in,
        input  rv_valid_out, rv_data_out, ph_ready_out, ph_valid_out,
               ph_data_out, ph_wait_out, mem_en_out, mem_addr_out
    );
endinterface

// File: rtl/track_map_arbiter.sv
// Track map BRAM read-port arbiter. Render fetches always win; physics lookups
// fill idle cycles. An owner-tag pipeline aligned with the BRAM latency steers
// each returning word to whichever side issued it.
// ADDR_W/DATA_W must match the parameters of the connected interface instance.
module track_map_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    track_map_arbiter_if.slave bus
);
    localparam logic OWN_RV = 1'b0;
    localparam logic OWN_PH = 1'b1;

    logic              w_rv_issue;
    logic              w_ph_issue;
    logic              w_issue;
    logic [ADDR_W-1:0] w_issue_addr;
    logic              w_tail_vld;
    logic              w_tail_own;

    logic              r_mem_en;
    logic [ADDR_W-1:0] r_mem_addr;
    // Stage 0 lines up with mem_en_out; stage RD_LAT lines up with mem_data_in.
    logic [RD_LAT:0]   r_tag_vld;
    logic [RD_LAT:0]   r_tag_own;
    logic              r_rv_valid;
    logic [DATA_W-1:0] r_rv_data;
    logic              r_ph_valid;
    logic [DATA_W-1:0] r_ph_data;
    logic [7:0]        r_ph_wait;

    // Fixed-priority pick of this cycle's read: render first, physics otherwise.
    always_comb begin
        w_rv_issue   = bus.rv_req_in;
        w_ph_issue   = bus.ph_req_in && !bus.rv_req_in;
        w_issue      = w_rv_issue || w_ph_issue;
        w_issue_addr = w_rv_issue ? bus.rv_addr_in : bus.ph_addr_in;
        w_tail_vld   = r_tag_vld[RD_LAT];
        w_tail_own   = r_tag_own[RD_LAT];
    end

    // Ready does not depend on reset; acceptances during reset are simply lost.
    assign bus.ph_ready_out = !bus.rv_req_in;

    // Register the BRAM port; address holds through idle cycles.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_mem_en <= w_issue;
            if (w_issue) begin
                r_mem_addr <= w_issue_addr;
            end
        end
    end

    // Owner-tag shift register tracking every read in flight.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_tag_vld <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[RD_LAT-1:0], w_issue};
            r_tag_own <= {r_tag_own[RD_LAT-1:0], (w_ph_issue ? OWN_PH : OWN_RV)};
        end
    end

    // Route returning data to its owner; data registers hold between pulses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rv_valid <= 1'b0;
            r_rv_data  <= '0;
            r_ph_valid <= 1'b0;
            r_ph_data  <= '0;
        end else begin
            r_rv_valid <= w_tail_vld && (w_tail_own == OWN_RV);
            r_ph_valid <= w_tail_vld && (w_tail_own == OWN_PH);
            if (w_tail_vld && (w_tail_own == OWN_RV)) begin
                r_rv_data <= bus.mem_data_in;
            end
            if (w_tail_vld && (w_tail_own == OWN_PH)) begin
                r_ph_data <= bus.mem_data_in;
            end
        end
    end

    // Saturating wait counter for a physics request blocked by render traffic.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_ph_wait <= 8'd0;
        end else if (bus.ph_req_in && bus.rv_req_in) begin
            if (r_ph_wait != 8'hFF) begin
                r_ph_wait <= r_ph_wait + 8'd1;
            end
        end else begin
            r_ph_wait <= 8'd0;
        end
    end

    assign bus.mem_en_out   = r_mem_en;
    assign bus.mem_addr_out = r_mem_addr;
    assign bus.rv_valid_out = r_rv_valid;
    assign bus.rv_data_out  = r_rv_data;
    assign bus.ph_valid_out = r_ph_valid;
    assign bus.ph_data_out  = r_ph_data;
    assign bus.ph_wait_out  = r_ph_wait;
endmodule

// File: tb/tb_track_map_arbiter.sv
// Bench for track_map_arbiter: two builds (RD_LAT=2 and RD_LAT=1) share stimulus.
// A transaction-level model predicts each response from its issue cycle plus latency.
module tb_track_map_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              rv_req  = 1'b0;
    logic [ADDR_W-1:0] rv_addr = '0;
    logic              ph_req  = 1'b0;
    logic [ADDR_W-1:0] ph_addr = '0;

    track_map_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2();
    track_map_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1();

    assign bus2.rv_req_in  = rv_req;
    assign bus2.rv_addr_in = rv_addr;
    assign bus2.ph_req_in  = ph_req;
    assign bus2.ph_addr_in = ph_addr;
    assign bus1.rv_req_in  = rv_req;
    assign bus1.rv_addr_in = rv_addr;
    assign bus1.ph_req_in  = ph_req;
    assign bus1.ph_addr_in = ph_addr;

    track_map_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2)) dut2 (
        .clk_in(clk), .rst_in(rst_n), .bus(bus2));
    track_map_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut1 (
        .clk_in(clk), .rst_in(rst_n), .bus(bus1));

    // BRAM models: word = addr[3:0], delivered RD_LAT cycles after mem_en_out.
    logic [3:0] p2a, p2b, p1a;
    always @(posedge clk) begin
        p2a <= bus2.mem_addr_out[3:0];
        p2b <= p2a;
        p1a <= bus1.mem_addr_out[3:0];
    end
    assign bus2.mem_data_in = p2b;
    assign bus1.mem_data_in = p1a;

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         cyc;
        bit         own;   // 1 = physics
        logic [3:0] data;
    } iss_t;
    iss_t iss_q[$];

    int          cyc_n = 0;
    logic        m_en = 1'b0;
    logic [13:0] m_addr = '0;
    logic [7:0]  m_wait = '0;
    logic        m_rv_v[2] = '{1'b0, 1'b0};
    logic        m_ph_v[2] = '{1'b0, 1'b0};
    logic [3:0]  m_rv_d[2] = '{4'h0, 4'h0};
    logic [3:0]  m_ph_d[2] = '{4'h0, 4'h0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q.delete();
            m_en = 1'b0;
            m_addr = '0;
            m_wait = '0;
            for (int k = 0; k < 2; k++) begin
                m_rv_v[k] = 1'b0; m_ph_v[k] = 1'b0;
                m_rv_d[k] = 4'h0; m_ph_d[k] = 4'h0;
            end
        end else begin
            cyc_n++;
            // responses: request sampled at edge c appears after edge c+lat+1
            for (int k = 0; k < 2; k++) begin
                int lat;
                lat = (k == 0) ? 2 : 1;
                m_rv_v[k] = 1'b0;
                m_ph_v[k] = 1'b0;
                foreach (iss_q[i]) begin
                    if (iss_q[i].cyc == cyc_n - lat - 1) begin
                        if (iss_q[i].own) begin m_ph_v[k] = 1'b1; m_ph_d[k] = iss_q[i].data; end
                        else              begin m_rv_v[k] = 1'b1; m_rv_d[k] = iss_q[i].data; end
                    end
                end
            end
            if (rv_req) begin
                iss_q.push_back('{cyc_n, 1'b0, rv_addr[3:0]});
                m_en = 1'b1; m_addr = rv_addr;
            end else if (ph_req) begin
                iss_q.push_back('{cyc_n, 1'b1, ph_addr[3:0]});
                m_en = 1'b1; m_addr = ph_addr;
            end else begin
                m_en = 1'b0;
            end
            if (ph_req && rv_req) m_wait = (m_wait == 8'd255) ? 8'd255 : m_wait + 8'd1;
            else                  m_wait = 8'd0;
            while (iss_q.size() > 0 && iss_q[0].cyc < cyc_n - 4) void'(iss_q.pop_front());
        end
    end

    // ---------------- per-cycle checker ----------------
    bit chk_en = 1'b0;
    int rv_cnt2 = 0, ph_cnt2 = 0, rv_cnt1 = 0, ph_cnt1 = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready2",  32'(bus2.ph_ready_out), 32'(!rv_req));
            chk("ready1",  32'(bus1.ph_ready_out), 32'(!rv_req));
            chk("en2",     32'(bus2.mem_en_out),   32'(m_en));
            chk("addr2",   32'(bus2.mem_addr_out), 32'(m_addr));
            chk("en1",     32'(bus1.mem_en_out),   32'(m_en));
            chk("addr1",   32'(bus1.mem_addr_out), 32'(m_addr));
            chk("wait2",   32'(bus2.ph_wait_out),  32'(m_wait));
            chk("wait1",   32'(bus1.ph_wait_out),  32'(m_wait));
            chk("rv_v2",   32'(bus2.rv_valid_out), 32'(m_rv_v[0]));
            chk("rv_d2",   32'(bus2.rv_data_out),  32'(m_rv_d[0]));
            chk("ph_v2",   32'(bus2.ph_valid_out), 32'(m_ph_v[0]));
            chk("ph_d2",   32'(bus2.ph_data_out),  32'(m_ph_d[0]));
            chk("rv_v1",   32'(bus1.rv_valid_out), 32'(m_rv_v[1]));
            chk("rv_d1",   32'(bus1.rv_data_out),  32'(m_rv_d[1]));
            chk("ph_v1",   32'(bus1.ph_valid_out), 32'(m_ph_v[1]));
            chk("ph_d1",   32'(bus1.ph_data_out),  32'(m_ph_d[1]));
            rv_cnt2 += int'(bus2.rv_valid_out);
            ph_cnt2 += int'(bus2.ph_valid_out);
            rv_cnt1 += int'(bus1.rv_valid_out);
            ph_cnt1 += int'(bus1.ph_valid_out);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        rv;
        logic [13:0] ra;
        logic        ph;
        logic [13:0] pa;
        logic        rdy;
    } vec_t;
    vec_t tbl[$];

    task automatic apply_vec(vec_t v);
        rv_req = v.rv; rv_addr = v.ra; ph_req = v.ph; ph_addr = v.pa;
        #1;
        chk("tbl_ready", 32'(bus2.ph_ready_out), 32'(v.rdy));
        @(posedge clk); #1;
    endtask

    task automatic apply_range(int lo, int hi);
        for (int i = lo; i < hi; i++) apply_vec(tbl[i]);
    endtask

    task automatic idle(int n);
        rv_req = 1'b0; ph_req = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int s_rv2, s_ph2, s_rv1, s_ph1;
    int lat2, lat1;
    bit prev_acc;

    initial begin
        // render-only 0..7, physics-only 8, interleave 9..24
        for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, 14'h0100 + 14'(i), 1'b0, 14'h0, 1'b0});
        tbl.push_back('{1'b0, 14'h0, 1'b1, 14'h0ABC, 1'b1});
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) tbl.push_back('{1'b1, 14'h0200 + 14'(i), 1'b0, 14'h0, 1'b0});
            else            tbl.push_back('{1'b0, 14'h0, 1'b1, 14'h0300 + 14'(i), 1'b1});
        end

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_en",   32'(bus2.mem_en_out),   32'h0);
        chk("rst_addr", 32'(bus2.mem_addr_out), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // render-only
        s_rv2 = rv_cnt2; s_ph2 = ph_cnt2; s_rv1 = rv_cnt1;
        apply_range(0, 8);
        idle(6);
        chk("ro_rv_cnt2", 32'(rv_cnt2 - s_rv2), 32'd8);
        chk("ro_ph_cnt2", 32'(ph_cnt2 - s_ph2), 32'd0);
        chk("ro_rv_cnt1", 32'(rv_cnt1 - s_rv1), 32'd8);
        chk("ro_last2",   32'(bus2.rv_data_out), 32'h7);

        // physics-only
        s_ph2 = ph_cnt2; s_ph1 = ph_cnt1;
        apply_range(8, 9);
        idle(6);
        chk("po_cnt2",  32'(ph_cnt2 - s_ph2), 32'd1);
        chk("po_cnt1",  32'(ph_cnt1 - s_ph1), 32'd1);
        chk("po_data2", 32'(bus2.ph_data_out), 32'hC);

        // interleave
        s_rv2 = rv_cnt2; s_ph2 = ph_cnt2; s_rv1 = rv_cnt1; s_ph1 = ph_cnt1;
        apply_range(9, 25);
        idle(6);
        chk("il_rv2", 32'(rv_cnt2 - s_rv2), 32'd8);
        chk("il_ph2", 32'(ph_cnt2 - s_ph2), 32'd8);
        chk("il_rv1", 32'(rv_cnt1 - s_rv1), 32'd8);
        chk("il_ph1", 32'(ph_cnt1 - s_ph1), 32'd8);

        // contention: physics starved for 300 cycles
        ph_req = 1'b1; ph_addr = 14'h0005;
        for (int i = 0; i < 300; i++) begin
            rv_req = 1'b1; rv_addr = 14'($urandom);
            @(posedge clk); #1;
        end
        chk("ct_wait_sat", 32'(bus2.ph_wait_out), 32'd255);
        rv_req = 1'b0;
        #1;
        chk("ct_ready", 32'(bus2.ph_ready_out), 32'd1);
        @(posedge clk); #1;
        chk("ct_wait_clr", 32'(bus2.ph_wait_out), 32'd0);
        ph_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("ct_ph_v",  32'(bus2.ph_valid_out), 32'd1);
        chk("ct_ph_d",  32'(bus2.ph_data_out),  32'h5);
        idle(4);

        // reset mid-flight
        for (int i = 0; i < 3; i++) begin
            rv_req = 1'b1; rv_addr = 14'h0011 + 14'(i);
            @(posedge clk); #1;
        end
        rv_req = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mr_rv_v", 32'(bus2.rv_valid_out), 32'd0);
        chk("mr_rv_d", 32'(bus2.rv_data_out),  32'd0);
        chk("mr_ph_d", 32'(bus2.ph_data_out),  32'd0);
        chk("mr_en",   32'(bus2.mem_en_out),   32'd0);
        chk("mr_addr", 32'(bus2.mem_addr_out), 32'd0);
        chk("mr_rv_d1", 32'(bus1.rv_data_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_rv2 = rv_cnt2; s_rv1 = rv_cnt1;
        idle(8);
        chk("mr_nopulse2", 32'(rv_cnt2 - s_rv2), 32'd0);
        chk("mr_nopulse1", 32'(rv_cnt1 - s_rv1), 32'd0);

        // latency after reset: 4 cycles (RD_LAT=2), 3 cycles (RD_LAT=1)
        rv_req = 1'b1; rv_addr = 14'h0033;
        lat2 = 0; lat1 = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) rv_req = 1'b0;
            if (lat2 == 0 && bus2.rv_valid_out) lat2 = n;
            if (lat1 == 0 && bus1.rv_valid_out) lat1 = n;
        end
        chk("lat2", 32'(lat2), 32'd4);
        chk("lat1", 32'(lat1), 32'd3);
        chk("lat_d2", 32'(bus2.rv_data_out), 32'h3);

        // randomized traffic with physics hold/drop behaviour
        for (int i = 0; i < 600; i++) begin
            prev_acc = ph_req && !rv_req;
            rv_req  = ($urandom_range(0, 99) < 55);
            rv_addr = 14'($urandom);
            if (ph_req && !prev_acc) begin
                if ($urandom_range(0, 9) == 0) ph_req = 1'b0;
            end else begin
                ph_req  = ($urandom_range(0, 2) != 0);
                ph_addr = 14'($urandom);
            end
            @(posedge clk); #1;
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
